mux4_rr_sequencer: RTL
======================

# mux4_rr_sequencer

Round-robin sequencer directly upstream of the 4:1 dataflow multiplexer (ports A0..A3, S0, S1, Y). It drives the mux select lines S0/S1 from four per-channel request lines, waits a programmable settle time, captures the mux output Y, and presents it downstream with a valid/ready handshake and the served channel number. It turns the combinational mux into a fair, flow-controlled 4-channel collector.

## Interface
- WIDTH, 4: data width; matches the mux `width` parameter.
- SETTLE, 1: cycles between select update and capture of `mux_y`; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit n means channel n (mux input An) holds data.
- mux_y  input  WIDTH  mux output Y.
- out_ready  input  1  downstream ready.
- S0  output  1  mux select MSB (channel bit 1); registered.
- S1  output  1  mux select LSB (channel bit 0); registered.
- out_data  output  WIDTH  captured sample; registered.
- out_ch  output  2  channel of out_data; registered.
- out_valid  output  1  out_data/out_ch valid.
- ack  output  4  one-hot, one-cycle pulse on the handshake cycle for the served channel.
- busy  output  1  high in any state except IDLE.

## Operation
- States: IDLE, SETTLE, HOLD.
- IDLE: if req != 0, pick the first requesting channel searching from last+1 upward, mod 4. Register S0 = ch[1], S1 = ch[0], cur = ch, cnt = SETTLE-1, then go to SETTLE. If req == 0, stay in IDLE; S0/S1 keep their values.
- SETTLE: if cnt == 0, capture mux_y into out_data, set out_ch = cur and out_valid = 1, then go to HOLD. Otherwise decrement cnt.
- HOLD: out_data, out_ch, S0 and S1 stay stable. On a cycle with out_valid & out_ready: ack[cur] pulses high in that same cycle (combinational from state & out_ready), and at the edge out_valid→0, last = cur, next state IDLE.
- req is sampled only in IDLE. If req[cur] drops during SETTLE or HOLD, the transaction still completes and ack still pulses.
- Fairness: a channel that has just been served has lowest priority in the next arbitration. With all four requesting, service order is 0,1,2,3,0…
- Width rule: out_data is an exact WIDTH-bit copy of mux_y. No arithmetic is performed.
- Reset values: S0 = 0, S1 = 0, out_data = 0, out_ch = 0, out_valid = 0, ack = 0, busy = 0, state = IDLE, cnt = 0, last = 3 (so channel 0 wins first).
- Reset mid-transaction: all of the above values apply at the next edge. No ack is issued and the sample is dropped.

## Timing
- Request seen in IDLE at edge T: S0/S1 show the new channel from T+1.
- mux_y is captured at edge T+SETTLE. out_valid is high from T+SETTLE.
- With out_ready held high, the handshake occurs in the first out_valid cycle, and IDLE is re-entered one cycle later.
- Minimum period per sample is SETTLE+2 cycles.
- out_valid never drops without a handshake. out_data never changes while out_valid is high.
- Back-pressure is unbounded: HOLD waits indefinitely for out_ready.

## Structure
- Package mux4_seq_pkg holds:
  - the state enum {IDLE, SETTLE, HOLD};
  - the 2-bit channel typedef;
  - the constant NCH = 4.
- Sub-module rr_pick4 is purely combinational. It takes req[3:0] and last[1:0] and returns grant_ch[1:0] and any_req. It is reusable for other 4-way round-robin sites.
- cnt width is $clog2(SETTLE+1). Add an elaboration check that 1 ≤ SETTLE ≤ 15.

## Test plan
- Reset then idle: hold rst for 2 cycles with req = 0 → all outputs 0, busy = 0, and S0/S1 = 0 for 10 cycles.
- Single request, SETTLE = 1: drive mux model with A2 = 4'hA, req = 4'b0100, out_ready = 1 → S0 = 1, S1 = 0 one cycle later; out_data = 4'hA and out_ch = 2 with out_valid a cycle after that; ack = 4'b0100 for one cycle.
- Round-robin with all requests: req = 4'hF, A0..A3 = 1,2,3,4, out_ready = 1 → out_ch sequence 0,1,2,3,0 and out_data sequence 1,2,3,4,1, one sample every 3 cycles.
- Back-pressure: out_ready = 0 for 5 cycles after out_valid rises; change mux_y meanwhile → out_data and S0/S1 stay constant and no ack occurs. Raise out_ready → one handshake, and ack pulses exactly once.
- Settle count, SETTLE = 3: change the mux_y model one cycle after the select changes → the captured value is the one present at edge T+3, and out_valid rises at T+3.
- Reset mid-HOLD: assert rst while out_valid = 1 → next cycle out_valid = 0, ack = 0, S0/S1 = 0; the next arbitration with req = 4'hF serves channel 0.

Source files
------------

// File: rtl/mux4_seq_pkg.sv
// ----------------------------------------------------------------------------
// mux4_seq_pkg
// Shared types and constants for the 4-channel round-robin mux sequencer.
//   NCH     : number of channels served (one per mux data input)
//   ch_t    : 2-bit channel index; bit 1 drives S0, bit 0 drives S1
//   state_t : sequencer states (idle / waiting for mux settle / holding sample)
// ----------------------------------------------------------------------------
package mux4_seq_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_t;

    // The ST_ prefix keeps the SETTLE state name from colliding with the
    // SETTLE parameter of the sequencer top.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
// Purely combinational 4-way round-robin picker.
//   req      in  4  request vector, bit n = channel n
//   last     in  2  channel served most recently (lowest priority now)
//   grant_ch out 2  first requesting channel searching last+1, last+2, ...
//   any_req  out 1  at least one request present (grant_ch valid)
// ----------------------------------------------------------------------------
module rr_pick4
    import mux4_seq_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  ch_t            last,
    output ch_t            grant_ch,
    output logic           any_req
);

    ch_t            base;   // highest-priority channel this round
    logic [NCH-1:0] rot;    // req rotated so that bit 0 is channel 'base'
    ch_t            pos;    // first set bit of rot
    ch_t            idx;

    assign base    = last + 2'd1;
    assign any_req = |req;

    // NOTE: every variable written in always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        rot = '0;
        idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx    = base + ch_t'(k);
            rot[k] = req[idx];
        end
    end

    always_comb begin
        pos = 2'd0;
        if      (rot[0]) pos = 2'd0;
        else if (rot[1]) pos = 2'd1;
        else if (rot[2]) pos = 2'd2;
        else if (rot[3]) pos = 2'd3;
    end

    // Undo the rotation; the 2-bit add wraps modulo 4.
    assign grant_ch = base + pos;

endmodule

// File: rtl/mux4_rr_sequencer.sv
// ----------------------------------------------------------------------------
// mux4_rr_sequencer
// Drives the select lines of a 4:1 mux from per-channel requests in fair
// round-robin order, waits SETTLE cycles, captures the mux output and offers
// it downstream with a valid/ready handshake.
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   req       in   4      per-channel request (sampled only when idle)
//   mux_y     in   WIDTH  mux output Y
//   out_ready in   1      downstream ready
//   S0        out  1      mux select MSB (channel bit 1), registered
//   S1        out  1      mux select LSB (channel bit 0), registered
//   out_data  out  WIDTH  captured sample, registered
//   out_ch    out  2      channel of out_data, registered
//   out_valid out  1      out_data/out_ch valid
//   ack       out  4      one-hot pulse for the served channel on handshake
//   busy      out  1      sequencer not idle
// ----------------------------------------------------------------------------
module mux4_rr_sequencer
    import mux4_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [WIDTH-1:0] mux_y,
    input  logic             out_ready,
    output logic             S0,
    output logic             S1,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic             out_valid,
    output logic [NCH-1:0]   ack,
    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
        $error("mux4_rr_sequencer: SETTLE must be within 1..15");
    end

    state_t           state;
    ch_t              cur;
    ch_t              last;
    logic [CNT_W-1:0] cnt;

    ch_t  grant_ch;
    logic any_req;

    rr_pick4 u_pick (
        .req      (req),
        .last     (last),
        .grant_ch (grant_ch),
        .any_req  (any_req)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            S0        <= 1'b0;
            S1        <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'd0;
            out_valid <= 1'b0;
            cur       <= 2'd0;
            cnt       <= '0;
            last      <= 2'd3;  // channel 0 wins the first arbitration
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        S0    <= grant_ch[1];
                        S1    <= grant_ch[0];
                        cur   <= grant_ch;
                        cnt   <= CNT_W'(SETTLE - 1);
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        out_data  <= mux_y;
                        out_ch    <= cur;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Selects and sample stay frozen until the consumer takes it.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        last      <= cur;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ack is combinational so it coincides with the handshake cycle itself.
    assign ack  = (state == ST_HOLD && out_valid && out_ready)
                  ? (NCH'(1) << cur) : '0;
    assign busy = (state != ST_IDLE);

endmodule
